// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants, note-code fields and state type for tone_sequencer
//
// Contents:
//   HP_W            width of a half-period value in clock cycles
//   SEMI_LSB/SEMI_W semitone field of a note code
//   OCT_LSB/OCT_W   octave-shift field of a note code
//   REST_THRESHOLD  semitone values at or above this are rests
//   state_t         sequencer states
//   base_hp()       equal-temperament half periods at 50 MHz, octave 0
//   note_hp()       half period after octave shift
//   note_is_rest()  rest detection
package tone_pkg;

    localparam int HP_W     = 17;
    localparam int SEMI_LSB = 0;
    localparam int SEMI_W   = 4;
    localparam int OCT_LSB  = 4;
    localparam int OCT_W    = 3;

    localparam logic [SEMI_W-1:0] REST_THRESHOLD = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Rest codes map to zero; the oscillator never looks at HP while resting.
    function automatic logic [HP_W-1:0] base_hp(input logic [SEMI_W-1:0] semi);
        case (semi)
            4'd0:    return 17'd95556;
            4'd1:    return 17'd90194;
            4'd2:    return 17'd85132;
            4'd3:    return 17'd80352;
            4'd4:    return 17'd75843;
            4'd5:    return 17'd71586;
            4'd6:    return 17'd67569;
            4'd7:    return 17'd63776;
            4'd8:    return 17'd60197;
            4'd9:    return 17'd56818;
            4'd10:   return 17'd53629;
            4'd11:   return 17'd50619;
            default: return 17'd0;
        endcase
    endfunction

    function automatic logic [HP_W-1:0] note_hp(input logic [SEMI_W-1:0] semi,
                                                input logic [OCT_W-1:0]  oct);
        return base_hp(semi) >> oct;
    endfunction

    function automatic logic note_is_rest(input logic [SEMI_W-1:0] semi);
        return semi >= REST_THRESHOLD;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - one square-wave tone channel with a half-period counter
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero the counter and force the wave low (wins over enable)
//   enable      advance the counter this cycle
//   rest        hold the wave low while enabled
//   hp          half period in clock cycles
//   wave        registered square wave
module tone_osc
    import tone_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic            rest,
    input  logic [HP_W-1:0] hp,
    output logic            wave
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (enable) begin
            if (rest) begin
                cnt  <= '0;
                wave <= 1'b0;
            end else if (cnt == hp - HP_W'(1)) begin
                cnt  <= '0;
                wave <= ~wave;
            end else begin
                cnt <= cnt + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - multi-channel square-wave step sequencer with writable step memory
//
// Ports:
//   CLK_50, RESET_N  50 MHz clock, asynchronous active-low reset
//   START, STOP      single-cycle controls; STOP wins
//   LOOP             replay from step 0 after the last step
//   SEQ_LEN          steps to play, latched on an accepted START
//   WR_EN/ADDR/DATA  step-memory write port, 8 bits of note code per channel
//   SPEAKER, MIX     per-channel square waves and their OR
//   BUSY, STEP, DONE activity flag, current step, end-of-sequence pulse
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 16,
    parameter int STEP_CYCLES = 2_500_000,
    parameter int GAP_CYCLES  = 250_000,
    localparam int AW         = $clog2(DEPTH),
    localparam int TW         = $clog2(STEP_CYCLES)
) (
    input  logic                  CLK_50,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  LOOP,
    input  logic [AW:0]           SEQ_LEN,
    input  logic                  WR_EN,
    input  logic [AW-1:0]         WR_ADDR,
    input  logic [8*CHANNELS-1:0] WR_DATA,
    output logic [CHANNELS-1:0]   SPEAKER,
    output logic                  MIX,
    output logic                  BUSY,
    output logic [AW-1:0]         STEP,
    output logic                  DONE
);

    // One LOAD cycle plus PLAY plus GAP adds up to STEP_CYCLES exactly.
    localparam logic [TW-1:0] PLAY_LAST = TW'(STEP_CYCLES - GAP_CYCLES - 2);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [TW-1:0]         timer;
    logic [AW:0]           seq_len;
    logic                  done_evt;
    logic                  play_end;
    logic                  gap_end;
    logic                  last_step;
    logic                  osc_clear;
    logic                  osc_enable;

    logic [8*CHANNELS-1:0] mem [DEPTH];
    logic [8*CHANNELS-1:0] rd_data;

    always_comb begin
        state_next = state;
        play_end   = (timer == PLAY_LAST);
        gap_end    = (timer == GAP_LAST);
        last_step  = ({1'b0, STEP} + (AW+1)'(1)) >= seq_len;
        if (STOP) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (START && SEQ_LEN != '0) state_next = ST_LOAD;
                ST_LOAD: state_next = ST_PLAY;
                ST_PLAY: if (play_end) state_next = ST_GAP;
                ST_GAP:  if (gap_end) state_next = (!last_step || LOOP) ? ST_LOAD : ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            timer    <= '0;
            STEP     <= '0;
            seq_len  <= '0;
            done_evt <= 1'b0;
            DONE     <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_next;
            BUSY     <= (state != ST_IDLE);
            // DONE trails the final GAP edge by one cycle so it lines up with BUSY falling.
            DONE     <= done_evt && !STOP;
            done_evt <= 1'b0;

            if (state_next == state && (state == ST_PLAY || state == ST_GAP))
                timer <= timer + TW'(1);
            else
                timer <= '0;

            if (STOP) begin
                STEP <= '0;
            end else if (state == ST_IDLE && state_next == ST_LOAD) begin
                STEP <= '0;
                // A length beyond the memory would let STEP wrap and never reach the end.
                seq_len <= (SEQ_LEN > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : SEQ_LEN;
            end else if (state == ST_GAP && gap_end) begin
                if (!last_step) begin
                    STEP <= STEP + AW'(1);
                end else begin
                    STEP     <= '0;
                    done_evt <= !LOOP;
                end
            end
        end
    end

    // Step memory has no reset so it maps onto block RAM; the read register
    // samples the old word when a write hits the same address in LOAD.
    always_ff @(posedge CLK_50) begin
        if (WR_EN)
            mem[WR_ADDR] <= WR_DATA;
        if (state == ST_LOAD)
            rd_data <= mem[STEP];
    end

    // STOP silences the outputs on the same edge that returns the FSM to IDLE.
    assign osc_clear  = (state != ST_PLAY) || STOP;
    assign osc_enable = (state == ST_PLAY);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0] code;
        logic       unused_bit7;

        assign code        = rd_data[8*c +: 8];
        assign unused_bit7 = code[7];

        tone_osc u_osc (
            .clk    (CLK_50),
            .rst_n  (RESET_N),
            .clear  (osc_clear),
            .enable (osc_enable),
            .rest   (note_is_rest(code[SEMI_LSB +: SEMI_W])),
            .hp     (note_hp(code[SEMI_LSB +: SEMI_W], code[OCT_LSB +: OCT_W])),
            .wave   (SPEAKER[c])
        );
    end

    assign MIX = |SPEAKER;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer against a cycle-offset model
module tb_tone_sequencer;

    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SC    = 2000;
    localparam int GAP   = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [AW:0]       seq_len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [8*CH-1:0]   wr_data;
    logic [CH-1:0]     speaker;
    logic              mix;
    logic              busy;
    logic [AW-1:0]     step;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_m    = 0;

    int              base_tab [12] = '{95556, 90194, 85132, 80352, 75843, 71586,
                                       67569, 63776, 60197, 56818, 53629, 50619};
    logic [8*CH-1:0] mem_m [DEPTH];
    int              inj_m [2];
    logic [AW-1:0]   inj_a [2];
    logic [8*CH-1:0] inj_d [2];

    tone_sequencer #(
        .CHANNELS    (CH),
        .DEPTH       (DEPTH),
        .STEP_CYCLES (SC),
        .GAP_CYCLES  (GAP)
    ) dut (
        .CLK_50  (clk),
        .RESET_N (rst_n),
        .START   (start),
        .STOP    (stop),
        .LOOP    (loop_en),
        .SEQ_LEN (seq_len),
        .WR_EN   (wr_en),
        .WR_ADDR (wr_addr),
        .WR_DATA (wr_data),
        .SPEAKER (speaker),
        .MIX     (mix),
        .BUSY    (busy),
        .STEP    (step),
        .DONE    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog m=%0d got=timeout exp=finish", cur_m);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s m=%0d got=%0h exp=%0h", tag, cur_m, got, exp);
    endtask

    // Expected wave o cycles after the cycle START was raised, within one step.
    function automatic logic exp_wave(input logic [7:0] code, input int o);
        int semi;
        int k;
        int hp;
        semi = int'(code[3:0]);
        k    = int'(code[6:4]);
        if (semi >= 12) return 1'b0;
        if (o < 2 || o > SC - GAP + 1) return 1'b0;
        hp = base_tab[semi] >> k;
        return ((o - 2) / hp) % 2 == 1;
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        c[7]   = 1'($urandom_range(0, 1));
        c[6:4] = 3'($urandom_range(5, 7));
        c[3:0] = 4'($urandom_range(0, 15));
        return c;
    endfunction

    task automatic write_mem(input int a, input logic [8*CH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        mem_m[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_speaker", 32'(speaker), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_step", 32'(step), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            @(negedge clk);
        end
    endtask

    // Starts a sequence from the current negedge and checks every following cycle.
    task automatic run_seq(input int len, input bit lp, input int ncyc,
                           input int stop_m, input int start_m, input int abort_m);
        logic [8*CH-1:0] cur;
        logic [CH-1:0]   e_spk;
        logic            e_busy;
        logic            e_done;
        int              e_step;
        int              s_abs;
        int              o;
        cur     = '0;
        seq_len = (AW+1)'(len);
        loop_en = lp;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int m = 1; m <= ncyc; m++) begin
            cur_m = m;
            s_abs = (m - 1) / SC;
            o     = m - s_abs * SC;
            if (stop_m >= 0 && m > stop_m) begin
                e_spk  = '0;
                e_step = 0;
                e_done = 1'b0;
                e_busy = (m == stop_m + 1);
            end else if (!lp && s_abs >= len) begin
                e_spk  = '0;
                e_step = 0;
                e_busy = (m <= len * SC + 1);
                e_done = (m == len * SC + 2);
            end else begin
                if (o == 1) cur = mem_m[s_abs % len];
                e_step = s_abs % len;
                e_busy = (m >= 2);
                e_done = 1'b0;
                for (int c = 0; c < CH; c++) e_spk[c] = exp_wave(cur[8*c +: 8], o);
            end
            check("speaker", 32'(speaker), 32'(e_spk));
            check("mix", 32'(mix), 32'(|e_spk));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("step", 32'(step), 32'(e_step));
            if (m == abort_m) return;
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
            if (m == stop_m) stop = 1'b1;
            if (m == start_m) begin
                start   = 1'b1;
                seq_len = (AW+1)'(1);
            end
            for (int i = 0; i < 2; i++) begin
                if (inj_m[i] == m) begin
                    wr_en   = 1'b1;
                    wr_addr = inj_a[i];
                    wr_data = inj_d[i];
                    mem_m[inj_a[i]] = inj_d[i];
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int len;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        seq_len = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 2; i++) inj_m[i] = -1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_mix", 32'(mix), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single steps: A octave 7 with a rest channel, two sounding channels, all rest.
        write_mem(0, 16'h0C79);
        run_seq(1, 1'b0, SC + 3, -1, -1, -1);
        write_mem(0, 16'h6079);
        run_seq(1, 1'b0, SC + 3, -1, -1, -1);
        write_mem(0, 16'h0F0C);
        run_seq(1, 1'b0, SC + 3, -1, -1, -1);

        // Three random steps with a START arriving mid-sequence.
        for (int a = 0; a < 3; a++) write_mem(a, {rand_code(), rand_code()});
        run_seq(3, 1'b0, 3 * SC + 3, -1, SC + 300, -1);

        // Loop mode: writes land mid-step and on the LOAD cycle of the same address.
        for (int a = 0; a < 3; a++) write_mem(a, {rand_code(), rand_code()});
        inj_m[0] = SC / 2;
        inj_a[0] = AW'(0);
        inj_d[0] = {rand_code(), rand_code()};
        inj_m[1] = SC + 1;
        inj_a[1] = AW'(1);
        inj_d[1] = {rand_code(), rand_code()};
        run_seq(3, 1'b1, 4 * SC + 910, 4 * SC + 900, -1, -1);
        for (int i = 0; i < 2; i++) inj_m[i] = -1;
        loop_en = 1'b0;
        check_idle(5);

        // START together with STOP, and START with zero length, are both ignored.
        seq_len = (AW+1)'(2);
        start   = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_idle(10);
        seq_len = '0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_idle(10);

        // Reset in the middle of step 1 while both channels are high.
        write_mem(0, {rand_code(), rand_code()});
        write_mem(1, 16'h7070);
        run_seq(2, 1'b0, SC + 801, -1, -1, SC + 801);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_speaker", 32'(speaker), 32'd0);
        check("arst_mix", 32'(mix), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_step", 32'(step), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(10);

        // Random non-loop sequences.
        repeat (3) begin
            len = $urandom_range(1, 3);
            for (int a = 0; a < len; a++) write_mem(a, {rand_code(), rand_code()});
            run_seq(len, 1'b0, len * SC + 3, -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Parametrised multi-channel square-wave tone sequencer for the board's GPIO speaker outputs. It holds a writable step memory of note codes and plays the steps in order at a fixed step duration, with an articulation gap between steps. It supports per-step octave shift, rests, loop mode and a start/stop control. It sits between the board-level control logic (buttons/switches or a host writer) and the GPIO speaker pins.

## Interface
- CHANNELS, 2: independent tone channels (1–8).
- DEPTH, 16: sequence steps (power of 2, ≥2); AW = $clog2(DEPTH).
- STEP_CYCLES, 2_500_000: clock cycles per step, including the gap.
- GAP_CYCLES, 250_000: silent cycles at the end of each step; must be < STEP_CYCLES − 1.
- CLK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle start request.
- STOP  in  1  single-cycle stop request.
- LOOP  in  1  restart at step 0 after the last step; level-sampled.
- SEQ_LEN  in  AW+1  number of steps to play; latched on an accepted START.
- WR_EN  in  1  step-memory write strobe.
- WR_ADDR  in  AW  step address.
- WR_DATA  in  8*CHANNELS  note codes; channel c uses bits [8c+7:8c].
- SPEAKER  out  CHANNELS  per-channel square waves.
- MIX  out  1  OR of all SPEAKER bits.
- BUSY  out  1  high whenever state ≠ IDLE.
- STEP  out  AW  index of the step currently loaded or playing.
- DONE  out  1  one-cycle pulse when a non-loop sequence ends.

## Operation
- Note code fields:
  - [3:0] semitone, 0=C … 11=B; values 12–15 are a rest.
  - [6:4] octave shift k.
  - [7] ignored.
- Half-period HP = BASE[semitone] >> k. BASE is in 50 MHz cycles, rounded equal temperament:
  - C 95556, C# 90194, D 85132, D# 80352, E 75843, F 71586.
  - F# 67569, G 63776, G# 60197, A 56818, A# 53629, B 50619.
  - All BASE values fit 17 bits.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - START with SEQ_LEN ≠ 0 and STOP low: latch SEQ_LEN, set STEP=0, go to LOAD.
  - START with SEQ_LEN = 0 is ignored.
- LOAD (1 cycle): registered memory read of STEP; clear all tone counters and force SPEAKER low. Go to PLAY.
- PLAY (STEP_CYCLES−GAP_CYCLES−1 cycles): per channel, the counter increments; at count == HP−1 the counter clears and SPEAKER toggles. A rest channel holds SPEAKER low.
- GAP (GAP_CYCLES cycles): all SPEAKER low. At the end of GAP:
  - If STEP < len−1: STEP+1, go to LOAD.
  - Else if LOOP=1: STEP=0, go to LOAD.
  - Else: pulse DONE, go to IDLE.
- The total cycle count per step is exactly STEP_CYCLES.
- STOP in any state: go to IDLE on the next edge, SPEAKER low, STEP=0, no DONE. STOP wins over a simultaneous START.
- START while BUSY is ignored.
- Writes are accepted in any state and take effect at the next LOAD of that address. If a write hits the address being read in the same LOAD cycle, the old data is returned (read-before-write).
- Step memory is not reset. It is inferred as RAM.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE; SPEAKER, MIX, BUSY, DONE, STEP all 0; all counters 0.
- Reset asserted mid-sequence forces these values immediately.
- START accepted at edge t0:
  - LOAD at t0+1.
  - First PLAY cycle at t0+2.
  - First SPEAKER rise at t0+2+HP.
- Full tone period = 2·HP cycles.
- SPEAKER, MIX, BUSY and DONE are registered. MIX is the OR of the registered SPEAKER bits (combinational, no added latency).
- Step timer width: $clog2(STEP_CYCLES).

## Structure
- Package tone_pkg contains:
  - BASE half-period table (17-bit constants);
  - note-code field positions and the REST threshold (12);
  - the state enum.
- Sub-module tone_osc: one instance per channel (generate loop). Inputs: clear, enable, rest, 17-bit HP. Output: a registered square wave.
- The sequencer FSM, step timer and memory live in tone_sequencer.

## Test plan
Parameters for all tests: STEP_CYCLES=400_000, GAP_CYCLES=40_000.
- Step 0 ch0 = 0x09, SEQ_LEN=1, START at t0 -> SPEAKER[0] rises at t0+56820, toggles every 56818 cycles, is low from t0+360002, DONE pulses at t0+400002, BUSY falls with it.
- Step 0 ch0 = 0x39, ch1 = 0x00 -> ch0 half-period 7102, ch1 half-period 95556; MIX = OR of both.
- Rest code 0x0C on ch0 -> SPEAKER[0] low for the whole step; BUSY high; STEP=0.
- LOOP=1, SEQ_LEN=3 -> STEP sequence 0,1,2,0,1 at 400_000-cycle spacing, no DONE; STOP -> IDLE next edge, SPEAKER=0, no DONE.
- START and STOP in the same IDLE cycle -> stays IDLE; START while BUSY -> no restart, STEP unaffected.
- RESET_N low mid-PLAY -> all outputs 0 asynchronously; after release, IDLE until the next START.
